// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer slice.
//   state_e     : frame-alignment FSM encoding (ST_IDLE=1'b0, ST_RUN=1'b1)
//   slot_width  : slot counter width for a given channel count (min 1 bit)
package tdm_demux_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int slot_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM demultiplexer.
//   clk, rst  : clock, asynchronous active-high reset (slot -> 0)
//   en        : advance one slot, wrapping from N_CH-1 to 0
//   load_one  : synchronous load of slot 1 (takes priority over en)
//   slot      : current slot index
//   last      : slot is N_CH-1
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter  int N_CH   = 4,
  localparam int SLOT_W = slot_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load_one,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);
  localparam logic [SLOT_W-1:0] ONE_SLOT  = SLOT_W'(1);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  assign last = (slot_q == LAST_SLOT);
  assign slot = slot_q;

  always_comb begin
    slot_d = slot_q;
    if (load_one) begin
      slot_d = ONE_SLOT;
    end else if (en) begin
      slot_d = last ? '0 : slot_q + ONE_SLOT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: distributes successive samples of one multiplexed lane
// to N_CH registered output channels, aligned by a frame_start marker.
//   clk, rst     : clock, asynchronous active-high reset
//   din          : multiplexed sample (DATA_W bits)
//   din_valid    : din carries a sample this cycle
//   frame_start  : din is slot 0 (only looked at when din_valid=1)
//   ch_data      : channel k at [k*DATA_W +: DATA_W], holds between updates
//   ch_valid     : per-channel one-cycle update strobe
//   frame_done   : one-cycle pulse when slot N_CH-1 is written
//   sync_err     : one-cycle pulse on frame_start arriving with slot != 0
//   locked       : FSM is in RUN
// Build option HOLD_FRAME_EN: samples collect in a shadow register and all
// channels update together (ch_valid all-ones) with frame_done.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 1,
  localparam int SLOT_W = slot_width(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     frame_start,
  output logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [N_CH-1:0]          ch_valid,
  output logic                     frame_done,
  output logic                     sync_err,
  output logic                     locked
);

  state_e                   state_q, state_d;
  logic [N_CH*DATA_W-1:0]   ch_data_q, ch_data_d;
  logic [N_CH-1:0]          ch_valid_q, ch_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     sync_err_q, sync_err_d;

  logic [SLOT_W-1:0]        slot;
  logic                     slot_last;
  logic                     cnt_en;
  logic                     cnt_load;
  logic                     wr_en;
  logic [SLOT_W-1:0]        wr_slot;

`ifdef HOLD_FRAME_EN
  logic [N_CH*DATA_W-1:0]   shadow_q, shadow_d;
`endif

  tdm_slot_counter #(
    .N_CH (N_CH)
  ) u_slot_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .load_one (cnt_load),
    .slot     (slot),
    .last     (slot_last)
  );

  always_comb begin
    state_d      = state_q;
    ch_data_d    = ch_data_q;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    wr_en        = 1'b0;
    wr_slot      = slot;

    if (din_valid) begin
      if (state_q == ST_IDLE) begin
        if (frame_start) begin
          wr_en    = 1'b1;
          wr_slot  = '0;
          cnt_load = 1'b1;
          state_d  = ST_RUN;
        end
      end else begin
        wr_en = 1'b1;
        if (frame_start && (slot != '0)) begin
          // Realign: the cut frame is abandoned, so no frame_done for it.
          sync_err_d = 1'b1;
          wr_slot    = '0;
          cnt_load   = 1'b1;
        end else begin
          cnt_en       = 1'b1;
          frame_done_d = slot_last;
        end
      end
    end

`ifdef HOLD_FRAME_EN
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d[int'(wr_slot)*DATA_W +: DATA_W] = din;
    end
    // Publish the shadow including the sample written this cycle.
    if (frame_done_d) begin
      ch_data_d  = shadow_d;
      ch_valid_d = '1;
    end
`else
    if (wr_en) begin
      ch_data_d[int'(wr_slot)*DATA_W +: DATA_W] = din;
      ch_valid_d[wr_slot]                       = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

`ifdef HOLD_FRAME_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == ST_RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (N_CH=4, DATA_W=1). Directed scenarios
// followed by randomized traffic, all compared against a frame-level model.
// Honours HOLD_FRAME_EN in the model when the build defines it.
module tb_tdm_demux;

  localparam int N_CH   = 4;
  localparam int DATA_W = 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DATA_W-1:0]      din;
  logic                   din_valid;
  logic                   frame_start;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_valid;
  logic                   frame_done;
  logic                   sync_err;
  logic                   locked;

  int checks   = 0;
  int failures = 0;

  tdm_demux #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .frame_done  (frame_done),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  // Reference model: frame position as a plain integer, channels as arrays.
  bit                m_aligned;
  int                m_pos;
  logic [DATA_W-1:0] m_chan   [N_CH];
  logic [DATA_W-1:0] m_shadow [N_CH];
  logic [N_CH-1:0]   e_valid;
  logic              e_done;
  logic              e_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_CH*DATA_W-1:0] model_data();
    logic [N_CH*DATA_W-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k*DATA_W +: DATA_W] = m_chan[k];
    return v;
  endfunction

  task automatic model_reset();
    m_aligned = 1'b0;
    m_pos     = 0;
    e_valid   = '0;
    e_done    = 1'b0;
    e_err     = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      m_chan[k]   = '0;
      m_shadow[k] = '0;
    end
  endtask

  // Place sample d at frame position p; completes a frame when p is the last.
  task automatic model_store(input int p, input logic [DATA_W-1:0] d, input bit completes);
`ifdef HOLD_FRAME_EN
    m_shadow[p] = d;
    if (completes) begin
      for (int k = 0; k < N_CH; k++) m_chan[k] = m_shadow[k];
      e_valid = '1;
    end
`else
    m_chan[p]  = d;
    e_valid[p] = 1'b1;
`endif
    e_done = completes;
  endtask

  task automatic model_accept(input logic v, input logic fs, input logic [DATA_W-1:0] d);
    e_valid = '0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    if (v) begin
      if (!m_aligned) begin
        if (fs) begin
          m_aligned = 1'b1;
          model_store(0, d, N_CH == 1);
          m_pos = 1;
        end
      end else if (fs && m_pos != 0) begin
        e_err = 1'b1;
        model_store(0, d, 1'b0);
        m_pos = 1;
      end else begin
        model_store(m_pos, d, m_pos == N_CH - 1);
        m_pos = (m_pos + 1) % N_CH;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data"},   64'(ch_data),    64'(model_data()));
    check({tag, ".valid"},  64'(ch_valid),   64'(e_valid));
    check({tag, ".done"},   64'(frame_done), 64'(e_done));
    check({tag, ".serr"},   64'(sync_err),   64'(e_err));
    check({tag, ".locked"}, 64'(locked),     64'(m_aligned));
  endtask

  task automatic step(input string tag, input logic v, input logic fs, input logic [DATA_W-1:0] d);
    @(negedge clk);
    din_valid   = v;
    frame_start = fs;
    din         = d;
    model_accept(v, fs, d);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    din_valid   = 1'b0;
    frame_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input string tag, input logic [N_CH-1:0] bits, input bit with_fs, input bit gaps);
    for (int i = 0; i < N_CH; i++) begin
      if (gaps) begin
        step({tag, ".gap"}, 1'b0, 1'b1, DATA_W'(i[0]));
      end
      step(tag, 1'b1, with_fs && (i == 0), DATA_W'(bits[i]));
    end
  endtask

  logic [N_CH*DATA_W-1:0] want_1101;

  initial begin
    want_1101   = 4'b1101;
    rst         = 1'b1;
    din         = '0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Unaligned samples are dropped.
    step("idle_drop", 1'b1, 1'b0, 1'b1);
    step("idle_drop", 1'b1, 1'b0, 1'b1);

    // Aligned frame 1,0,1,1.
    send_frame("frame", 4'b1101, 1'b1, 1'b0);
    check("frame.final", 64'(ch_data), 64'(want_1101));

    // Same frame with idle cycles (frame_start high while invalid is ignored).
    send_frame("gaps", 4'b1101, 1'b1, 1'b1);
    check("gaps.final", 64'(ch_data), 64'(want_1101));

    // Resync on third sample.
    step("resync", 1'b1, 1'b1, 1'b0);
    step("resync", 1'b1, 1'b0, 1'b1);
    step("resync", 1'b1, 1'b1, 1'b1);
    step("resync", 1'b1, 1'b0, 1'b0);
    step("resync", 1'b1, 1'b0, 1'b1);
    step("resync", 1'b1, 1'b0, 1'b0);

    // Three back-to-back frames, marker only on the first.
    apply_reset("reset_mid");
    send_frame("wrap", 4'b1010, 1'b1, 1'b0);
    send_frame("wrap", 4'b0110, 1'b0, 1'b0);
    send_frame("wrap", 4'b1111, 1'b0, 1'b0);

    // Reset in the middle of a frame, then unaligned traffic.
    step("partial", 1'b1, 1'b1, 1'b1);
    step("partial", 1'b1, 1'b0, 1'b1);
    apply_reset("reset_partial");
    step("post_reset", 1'b1, 1'b0, 1'b1);

    // Randomized traffic with occasional mid-stream reset.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        apply_reset("rand_reset");
      end else begin
        step("rand",
             ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 9) == 0),
             DATA_W'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
